pulse_train_controller: RTL and testbench
=========================================

// Module: pulse_train_controller
// PURPOSE
//   Sequences a programmable burst of periodic single-cycle pulses: initial delay, then N pulses
//   spaced P cycles apart. Adds start/abort/busy/done control to the free-running periodic pulse
//   generator function. Sits between a host/config master and trigger-driven logic.
// PARAMETERS
//   TIMER_WIDTH  16  width of delay/period timer and of cfg_delay/cfg_period
//   COUNT_WIDTH  8   width of the pulse count (cfg_count, pulses_left)
// PORTS
//   clk          in   1            system clock, all logic on posedge
//   rst          in   1            asynchronous, active-high reset
//   start        in   1            request a burst; accepted only in IDLE
//   abort        in   1            terminate active burst
//   cfg_delay    in   TIMER_WIDTH  D: extra cycles before first pulse
//   cfg_period   in   TIMER_WIDTH  P: cycles between pulses; 0 treated as 1
//   cfg_count    in   COUNT_WIDTH  N: number of pulses; 0 = empty burst
//   pulse        out  1            registered pulse output, one cycle per pulse
//   busy         out  1            burst in progress
//   done         out  1            one-cycle strobe: burst completed normally
//   aborted      out  1            one-cycle strobe: burst terminated by abort
//   pulses_left  out  COUNT_WIDTH  pulses still to be issued in current burst
// BEHAVIOUR
// - Reset (async, any time incl. mid-burst): state=IDLE; pulse, busy, done, aborted = 0;
//   pulses_left = 0; timer = 0. First edge after rst deasserts behaves as IDLE.
// - States: IDLE, DELAY, RUN. done/aborted are registered strobes, not states.
// - IDLE: start=1 at edge E0 -> latch D, Pe=max(P,1), N; busy=1, pulses_left=N from E0.
//   If N=0: at E0 go straight to IDLE with done=1, busy=0, no pulse.
//   Else -> DELAY, timer loaded with D.
// - DELAY: timer decrements each edge; at the edge where timer==0 -> RUN.
//   First pulse is registered high at edge E0+D+1 (high for the following cycle only).
// - RUN: pulse k (k=1..N) registered at edge E0+D+1+(k-1)*Pe; pulse=0 at all other edges.
//   pulses_left decrements at each pulse edge. Pe=1 => pulse high N consecutive cycles.
// - Completion: at edge after the N-th pulse edge: pulse=0, busy=0, done=1, -> IDLE.
//   done and aborted are high exactly one cycle.
// - start while busy: ignored, config not re-latched; cfg_* changes mid-burst no effect.
// - abort in DELAY/RUN: at next edge pulse=0, busy=0, pulses_left=0, aborted=1, -> IDLE;
//   abort wins over a pulse or completion due on that same edge (no pulse, no done).
// - abort in IDLE: ignored; if start also high, start is accepted.
// - Back-to-back: start high during the cycle done (or aborted) is high is accepted in IDLE;
//   new burst's busy rises at that edge.
// - Timer arithmetic: unsigned, TIMER_WIDTH bits, counts down to 0, reloads Pe-1 after each
//   pulse; no wrap. D=2^TIMER_WIDTH-1 and P=2^TIMER_WIDTH-1 must work.
// - Counts are unsigned; N=2^COUNT_WIDTH-1 must issue exactly that many pulses.
// TESTING
// - Reset: assert rst mid-burst asynchronously -> all outputs 0 immediately, no further pulses.
// - D=0,P=3,N=4, start at E0 -> pulses at E1,E4,E7,E10; done=1 at E11; busy E0..E10.
// - D=5,P=0,N=3 -> pulses at E6,E7,E8 (P=0 acts as 1); done at E9.
// - N=0 -> done=1 at E0 edge, busy never observed high, zero pulses.
// - D=0,P=4,N=5, abort during cycle after second pulse (E5) -> pulses only E1,E5; at E6
//   aborted=1, busy=0; abort on a pulse edge suppresses that pulse; start while busy ignored.
// - Back-to-back: start held high continuously with D=1,P=2,N=2 -> pulses E2,E4, done E5,
//   new burst accepted at E5, pulses E7,E9; pulses_left traces 2,1,0 each burst.

Source files
------------

// File: rtl/pulse_train_controller.sv
// Burst pulse sequencer: after an initial delay, issues N single-cycle pulses spaced P cycles apart,
// with start/abort control and busy/done/aborted status.
module pulse_train_controller #(
    parameter int TIMER_WIDTH = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TIMER_WIDTH-1:0] cfg_delay,
    input  logic [TIMER_WIDTH-1:0] cfg_period,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    output logic                   pulse,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [COUNT_WIDTH-1:0] pulses_left
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

    state_t                 state, state_d;
    logic [TIMER_WIDTH-1:0] timer, timer_d;
    // Holds Pe-1, the value the timer reloads with after each pulse.
    logic [TIMER_WIDTH-1:0] reload, reload_d;
    logic [COUNT_WIDTH-1:0] left_d;
    logic                   pulse_d, busy_d, done_d, aborted_d;
    logic                   finishing, accept;

    // The completion edge behaves like IDLE for start, so a held start chains bursts without a gap.
    assign finishing = (state == RUN) && (pulses_left == '0);
    assign accept    = start && ((state == IDLE) || (finishing && !abort));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            reload      <= '0;
            pulses_left <= '0;
            pulse       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            reload      <= reload_d;
            pulses_left <= left_d;
            pulse       <= pulse_d;
            busy        <= busy_d;
            done        <= done_d;
            aborted     <= aborted_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state;
        timer_d   = timer;
        reload_d  = reload;
        left_d    = pulses_left;
        pulse_d   = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (state != IDLE && abort) begin
            state_d   = IDLE;
            timer_d   = '0;
            left_d    = '0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state)
                DELAY: begin
                    if (timer == '0) begin
                        pulse_d = 1'b1;
                        left_d  = pulses_left - 1'b1;
                        timer_d = reload;
                        state_d = RUN;
                    end else begin
                        timer_d = timer - 1'b1;
                    end
                end
                RUN: begin
                    if (finishing) begin
                        state_d = IDLE;
                        timer_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (timer == '0) begin
                        pulse_d = 1'b1;
                        left_d  = pulses_left - 1'b1;
                        timer_d = reload;
                    end else begin
                        timer_d = timer - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            reload_d = (cfg_period == '0) ? '0 : cfg_period - 1'b1;
            if (cfg_count == '0) begin
                state_d = IDLE;
                timer_d = '0;
                left_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = DELAY;
                timer_d = cfg_delay;
                left_d  = cfg_count;
                busy_d  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_controller.sv
// Self-checking bench for pulse_train_controller: expected outputs are derived per edge from the
// burst timing formulas (first pulse at D+1, then every max(P,1) edges, done one edge after the last).
module tb_pulse_train_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [15:0] cfg_delay, cfg_period;
    logic [7:0]  cfg_count;
    logic        pulse, busy, done, aborted;
    logic [7:0]  pulses_left;

    int total = 0;
    int bad   = 0;

    pulse_train_controller #(.TIMER_WIDTH(16), .COUNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_period(cfg_period), .cfg_count(cfg_count),
        .pulse(pulse), .busy(busy), .done(done), .aborted(aborted), .pulses_left(pulses_left)
    );

    always #5 clk = ~clk;

    // Runs one burst started at edge E0 and compares {pulse,busy,done,aborted,pulses_left} after
    // every edge. a = edge index of the abort (0 = no abort). Start and cfg_* are scrambled while
    // the burst is active to show they are ignored.
    task automatic run_burst(input string name, input int d, input int p, input int n, input int a);
        int pe, last, end_t, npulses;
        logic [11:0] exp_v, got_v;
        pe    = (p == 0) ? 1 : p;
        last  = (n == 0) ? 0 : d + 1 + (n - 1) * pe;
        end_t = (n == 0) ? 0 : ((a != 0) ? a : last + 1);
        @(negedge clk);
        cfg_delay  = 16'(d);
        cfg_period = 16'(p);
        cfg_count  = 8'(n);
        start      = 1'b1;
        abort      = (a == 0 && n != 0) ? 1'b0 : 1'b0;
        for (int t = 0; t <= end_t + 2; t++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = '0;
            if (n == 0) begin
                exp_v[9] = (t == 0);
            end else if (a != 0 && t >= a) begin
                exp_v[8] = (t == a);
            end else begin
                exp_v[11] = (t >= d + 1) && (t <= last) && ((t - d - 1) % pe == 0);
                exp_v[10] = (t <= last);
                exp_v[9]  = (t == last + 1);
                npulses   = (t >= d + 1) ? ((t - d - 1) / pe + 1) : 0;
                if (npulses > n) npulses = n;
                exp_v[7:0] = 8'(n - npulses);
            end
            got_v = {pulse, busy, done, aborted, pulses_left};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s t=%0d {pulse,busy,done,aborted,left} got=%b/%0d want=%b/%0d",
                         name, t, got_v[11:8], got_v[7:0], exp_v[11:8], exp_v[7:0]);
            end
            start      = (n != 0 && t + 1 < end_t) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort      = (a != 0 && t + 1 == a);
            cfg_delay  = 16'($urandom);
            cfg_period = 16'($urandom);
            cfg_count  = 8'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_delay = '0; cfg_period = '0; cfg_count = '0;
        #1;
        total++;
        if ({pulse, busy, done, aborted, pulses_left} !== 12'h0) begin
            bad++;
            $display("FAIL reset_initial got=%b want=0", {pulse, busy, done, aborted, pulses_left});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        cfg_delay = 16'd0; cfg_period = 16'd1; cfg_count = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pulse, busy, done, aborted, pulses_left} !== 12'h0) begin
            bad++;
            $display("FAIL reset_async got=%b want=0", {pulse, busy, done, aborted, pulses_left});
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b0;
            @(negedge clk);
            total++;
            if ({pulse, busy, done, aborted, pulses_left} !== 12'h0) begin
                bad++;
                $display("FAIL reset_after cyc=%0d got=%b want=0", i,
                         {pulse, busy, done, aborted, pulses_left});
            end
        end
    endtask

    task automatic test_directed();
        run_burst("d0_p3_n4", 0, 3, 4, 0);
        run_burst("d5_p0_n3", 5, 0, 3, 0);
        run_burst("n0_empty", 7, 2, 0, 0);
        run_burst("abort_after_pulse2", 0, 4, 5, 6);
        run_burst("abort_on_pulse_edge", 0, 4, 5, 9);
        run_burst("abort_on_done_edge", 1, 1, 2, 4);
        run_burst("abort_in_delay", 6, 2, 3, 3);
        run_burst("max_count", 0, 0, 255, 0);
        run_burst("max_period", 0, 65535, 2, 0);
    endtask

    task automatic test_back_to_back();
        // Expected per edge with start held: {pulse,busy,done} and pulses_left.
        logic [2:0] exp_pbd  [12] = '{3'b010, 3'b010, 3'b110, 3'b010, 3'b110, 3'b011,
                                      3'b010, 3'b110, 3'b010, 3'b110, 3'b001, 3'b000};
        int         exp_left [12] = '{2, 2, 1, 1, 0, 2, 2, 1, 1, 0, 0, 0};
        @(negedge clk);
        cfg_delay = 16'd1; cfg_period = 16'd2; cfg_count = 8'd2; start = 1'b1; abort = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            total++;
            if ({pulse, busy, done, aborted, pulses_left} !== {exp_pbd[t], 1'b0, 8'(exp_left[t])}) begin
                bad++;
                $display("FAIL back_to_back t=%0d got=%b/%0d want=%b0/%0d", t,
                         {pulse, busy, done, aborted}, pulses_left, exp_pbd[t], exp_left[t]);
            end
            if (t == 9) start = 1'b0;
        end
    endtask

    task automatic test_random();
        int d, p, n, a, pe, last;
        for (int i = 0; i < 25; i++) begin
            d  = $urandom_range(0, 20);
            p  = $urandom_range(0, 6);
            n  = $urandom_range(0, 12);
            pe = (p == 0) ? 1 : p;
            last = d + 1 + (n - 1) * pe;
            a  = (n != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, last + 1) : 0;
            run_burst("random", d, p, n, a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
